// File: rtl/accum_pkg.sv
// Shared encodings for the MAC accumulator: operation modes and FSM states.
// Pure declarations, no logic; imported by accum_alu and mac_accumulator.
// No flow control of its own.
package accum_pkg;

  typedef enum logic [1:0] {
    MODE_ADD   = 2'b00,
    MODE_MAC   = 2'b01,
    MODE_SUB   = 2'b10,
    MODE_ADDXY = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/accum_alu.sv
// Next accumulator value and overflow/underflow bit for one sample.
// Purely combinational, zero latency; no flow control, the caller decides when to commit.
module accum_alu
  import accum_pkg::*;
#(
  parameter int K        = 8,
  parameter int M        = 8,
  parameter int W        = 20,
  parameter int SATURATE = 1
) (
  input  logic [W-1:0] acc,
  input  logic [1:0]   mode,
  input  logic [K-1:0] x,
  input  logic [M-1:0] y,
  output logic [W-1:0] nxt,
  output logic         ovf
);

  logic [K+M-1:0] prod;
  logic [W:0]     acc_e, x_e, y_e, prod_e, sum;
  logic           under, over;

  assign prod   = {{M{1'b0}}, x} * {{K{1'b0}}, y};
  assign acc_e  = {1'b0, acc};
  assign x_e    = {{(W+1-K){1'b0}}, x};
  assign y_e    = {{(W+1-M){1'b0}}, y};
  assign prod_e = {{(W+1-K-M){1'b0}}, prod};

  always_comb begin
    sum   = '0;
    under = 1'b0;
    case (mode)
      MODE_ADD: sum = acc_e + x_e;
      MODE_MAC: sum = acc_e + prod_e;
      MODE_SUB: begin
        sum   = acc_e - x_e;
        under = (acc_e < x_e);
      end
      default:  sum = acc_e + x_e + y_e;
    endcase
    // A borrow also sets sum[W], so it must not be mistaken for a carry.
    over = sum[W] & ~under;
    ovf  = over | under;
    if (SATURATE != 0 && over)
      nxt = '1;
    else if (SATURATE != 0 && under)
      nxt = '0;
    else
      nxt = sum[W-1:0];
  end

endmodule

// File: rtl/mac_accumulator.sv
// Multiply/add accumulator running N tick-qualified samples per run (IDLE/RUN/DONE).
// Result visible one cycle after the qualifying tick edge; done pulses for one cycle on entry to DONE.
// No backpressure: tick is a one-cycle enable, hold freezes accumulation while in RUN.
module mac_accumulator
  import accum_pkg::*;
#(
  parameter int K        = 8,
  parameter int M        = 8,
  parameter int W        = 20,
  parameter int N        = 4,
  parameter int SATURATE = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tick,
  input  logic                       start,
  input  logic                       clear,
  input  logic                       hold,
  input  logic [1:0]                 mode,
  input  logic [K-1:0]               X,
  input  logic [M-1:0]               Y,
  output logic [W-1:0]               result,
  output logic [$clog2(N+1)-1:0]     count,
  output logic                       busy,
  output logic                       done,
  output logic                       ovf
);

  localparam int CW = $clog2(N+1);

  generate
    if (W < K + M) begin : g_bad_width
      $error("mac_accumulator: W must be at least K+M");
    end
    if (N < 1) begin : g_bad_n
      $error("mac_accumulator: N must be at least 1");
    end
  endgenerate

  state_e        state_q, state_d;
  logic [W-1:0]  result_d;
  logic [CW-1:0] count_d;
  logic          ovf_d, done_d;
  logic [W-1:0]  alu_nxt;
  logic          alu_ovf;

  accum_alu #(
    .K(K), .M(M), .W(W), .SATURATE(SATURATE)
  ) u_alu (
    .acc (result),
    .mode(mode),
    .x   (X),
    .y   (Y),
    .nxt (alu_nxt),
    .ovf (alu_ovf)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result;
    count_d  = count;
    ovf_d    = ovf;
    done_d   = 1'b0;
    if (clear) begin
      state_d  = ST_IDLE;
      result_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else if (start) begin
      // Restart from any state; a tick in the same cycle is dropped.
      state_d  = ST_RUN;
      result_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else if (state_q == ST_RUN && tick && !hold) begin
      result_d = alu_nxt;
      count_d  = count + CW'(1);
      ovf_d    = ovf | alu_ovf;
      if (count == CW'(N - 1)) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      result  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      result  <= result_d;
      count   <= count_d;
      ovf     <= ovf_d;
      done    <= done_d;
    end
  end

  assign busy = (state_q == ST_RUN);

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboarded bench for mac_accumulator: main instance K=8 M=8 W=20 N=4 saturating,
// plus a W=16 saturating and a W=20 wrapping instance sharing the same stimulus.
module tb_mac_accumulator;
  import accum_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, tick, start, clear, hold;
  logic [1:0]  mode;
  logic [7:0]  X, Y;

  logic [19:0] result;  logic [2:0] count;  logic busy,  done,  ovf;
  logic [15:0] r16;     logic [2:0] c16;    logic busy16, done16, ovf16;
  logic [19:0] rw;      logic [2:0] cw;     logic busyw, donew, ovfw;

  mac_accumulator #(.K(8), .M(8), .W(20), .N(4), .SATURATE(1)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .clear(clear), .hold(hold),
    .mode(mode), .X(X), .Y(Y), .result(result), .count(count), .busy(busy), .done(done), .ovf(ovf));

  mac_accumulator #(.K(8), .M(8), .W(16), .N(4), .SATURATE(1)) dut16 (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .clear(clear), .hold(hold),
    .mode(mode), .X(X), .Y(Y), .result(r16), .count(c16), .busy(busy16), .done(done16), .ovf(ovf16));

  mac_accumulator #(.K(8), .M(8), .W(20), .N(4), .SATURATE(0)) dutw (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .clear(clear), .hold(hold),
    .mode(mode), .X(X), .Y(Y), .result(rw), .count(cw), .busy(busyw), .done(donew), .ovf(ovfw));

  typedef struct {
    logic [19:0] res;
    logic [2:0]  cnt;
    logic        ovf;
    logic        dn;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    passed = 0;

  // Reference model of the main (W=20, saturating) instance.
  longint m_acc;
  int     m_cnt;
  bit     m_ovf;
  bit     m_run;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_start();
    m_acc = 0; m_cnt = 0; m_ovf = 0; m_run = 1;
  endtask

  task automatic model_tick(input logic [1:0] md, input logic [7:0] xv, input logic [7:0] yv);
    longint s;
    exp_t   e;
    logic [19:0] r;
    case (md)
      2'b00:   s = m_acc + longint'(xv);
      2'b01:   s = m_acc + longint'(xv) * longint'(yv);
      2'b10:   s = m_acc - longint'(xv);
      default: s = m_acc + longint'(xv) + longint'(yv);
    endcase
    if (s < 0) begin
      m_acc = 0; m_ovf = 1;
    end else if (s >= 64'd1048576) begin
      m_acc = 64'd1048575; m_ovf = 1;
    end else begin
      m_acc = s;
    end
    m_cnt++;
    r     = m_acc[19:0];
    e.res = r;
    e.cnt = 3'(m_cnt);
    e.ovf = m_ovf;
    e.dn  = (m_cnt == 4);
    if (m_cnt == 4) m_run = 0;
    sb.push_back(e);
  endtask

  function automatic exp_t pop_exp();
    exp_t e;
    e.res = 'x; e.cnt = 'x; e.ovf = 1'bx; e.dn = 1'bx;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    model_start();
  endtask

  task automatic tick_once(input logic [1:0] md, input logic [7:0] xv, input logic [7:0] yv,
                           input logic hv);
    mode = md; X = xv; Y = yv; hold = hv; tick = 1'b1;
    if (!hv && m_run) model_tick(md, xv, yv);
    step();
    tick = 1'b0; hold = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({result, count, busy, done, ovf} !== 27'd0)
      $display("FAIL reset_state: got %h want 0", {result, count, busy, done, ovf});
    else passed++;
    reset = 1'b0;
    step();
    checks++;
    if ({busy, result} !== 21'd0)
      $display("FAIL idle_after_reset: got %h want 0", {busy, result});
    else passed++;
  endtask

  task automatic test_add();
    exp_t e;
    do_start();
    checks++;
    if ({result, count, busy, done, ovf} !== {20'd0, 3'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL add_start: got %h want busy only", {result, count, busy, done, ovf});
    else passed++;
    for (int i = 0; i < 4; i++) begin
      tick_once(MODE_ADD, 8'd3, 8'd0, 1'b0);
      e = pop_exp();
      checks++;
      if ({result, count, ovf, done} !== {e.res, e.cnt, e.ovf, e.dn})
        $display("FAIL add_tick%0d: got %h want %h", i, {result, count, ovf, done},
                 {e.res, e.cnt, e.ovf, e.dn});
      else passed++;
    end
    checks++;
    if ({result, count, busy, done, ovf} !== {20'd12, 3'd4, 1'b0, 1'b1, 1'b0})
      $display("FAIL add_final: got %h want %h", {result, count, busy, done, ovf},
               {20'd12, 3'd4, 1'b0, 1'b1, 1'b0});
    else passed++;
    step();
    checks++;
    if ({result, count, busy, done} !== {20'd12, 3'd4, 1'b0, 1'b0})
      $display("FAIL add_done_hold: got %h want %h", {result, count, busy, done},
               {20'd12, 3'd4, 1'b0, 1'b0});
    else passed++;
  endtask

  task automatic test_mac();
    exp_t e;
    do_start();
    for (int i = 0; i < 4; i++) begin
      tick_once(MODE_MAC, 8'd255, 8'd255, 1'b0);
      e = pop_exp();
      checks++;
      if ({result, count, ovf} !== {e.res, e.cnt, e.ovf})
        $display("FAIL mac_tick%0d: got %h want %h", i, {result, count, ovf}, {e.res, e.cnt, e.ovf});
      else passed++;
    end
    checks++;
    if ({result, ovf} !== {20'd260100, 1'b0})
      $display("FAIL mac_w20: got %0d/%0d want 260100/0", result, ovf);
    else passed++;
    checks++;
    if ({r16, ovf16, done16} !== {16'd65535, 1'b1, 1'b1})
      $display("FAIL mac_w16_sat: got %0d/%0d/%0d want 65535/1/1", r16, ovf16, done16);
    else passed++;
  endtask

  task automatic test_sub();
    exp_t e;
    do_start();
    tick_once(MODE_SUB, 8'd5, 8'd0, 1'b0);
    e = pop_exp();
    checks++;
    if ({result, count, ovf} !== {e.res, e.cnt, e.ovf})
      $display("FAIL sub_sat: got %h want %h", {result, count, ovf}, {e.res, e.cnt, e.ovf});
    else passed++;
    checks++;
    if ({result, ovf} !== {20'd0, 1'b1})
      $display("FAIL sub_sat_const: got %0d/%0d want 0/1", result, ovf);
    else passed++;
    checks++;
    if ({rw, ovfw} !== {20'd1048571, 1'b1})
      $display("FAIL sub_wrap: got %0d/%0d want 1048571/1", rw, ovfw);
    else passed++;
    tick_once(MODE_ADD, 8'd1, 8'd0, 1'b0);
    e = pop_exp();
    checks++;
    if ({result, ovf} !== {e.res, e.ovf})
      $display("FAIL ovf_sticky: got %0d/%0d want %0d/%0d", result, ovf, e.res, e.ovf);
    else passed++;
    do_start();
    checks++;
    if ({result, ovf, ovfw} !== {20'd0, 1'b0, 1'b0})
      $display("FAIL ovf_clear_on_start: got %h want 0", {result, ovf, ovfw});
    else passed++;
  endtask

  task automatic test_hold();
    tick_once(MODE_ADD, 8'd7, 8'd0, 1'b0);
    tick_once(MODE_ADD, 8'd7, 8'd0, 1'b1);
    checks++;
    if ({result, count} !== {20'd7, 3'd1})
      $display("FAIL hold_freeze: got %0d/%0d want 7/1", result, count);
    else passed++;
    tick_once(MODE_ADD, 8'd7, 8'd0, 1'b0);
    tick_once(MODE_ADD, 8'd7, 8'd0, 1'b0);
    void'(pop_exp()); void'(pop_exp());
    checks++;
    if ({result, count, busy} !== {20'd21, 3'd3, 1'b1})
      $display("FAIL hold_final: got %0d/%0d/%0d want 21/3/1", result, count, busy);
    else passed++;
    void'(pop_exp());
    step();
    checks++;
    if ({result, count, busy} !== {20'd21, 3'd3, 1'b1})
      $display("FAIL no_tick_idle_cycle: got %0d/%0d/%0d want 21/3/1", result, count, busy);
    else passed++;
  endtask

  task automatic test_priority();
    exp_t e;
    tick_once(MODE_ADD, 8'd7, 8'd0, 1'b0);
    e = pop_exp();
    checks++;
    if ({result, count, done, busy} !== {e.res, e.cnt, e.dn, 1'b0})
      $display("FAIL prio_to_done: got %h want %h", {result, count, done, busy}, {e.res, e.cnt, e.dn, 1'b0});
    else passed++;
    tick_once(MODE_ADD, 8'd9, 8'd0, 1'b1);
    start = 1'b1; clear = 1'b1;
    step();
    start = 1'b0; clear = 1'b0; m_run = 0; m_acc = 0; m_cnt = 0; m_ovf = 0;
    checks++;
    if ({result, count, busy, done, ovf} !== 27'd0)
      $display("FAIL prio_clear_over_start: got %h want 0", {result, count, busy, done, ovf});
    else passed++;
    do_start();
    tick_once(MODE_ADD, 8'd3, 8'd0, 1'b0);
    tick_once(MODE_ADD, 8'd3, 8'd0, 1'b0);
    void'(pop_exp()); void'(pop_exp());
    start = 1'b1; tick = 1'b1; X = 8'd9;
    step();
    start = 1'b0; tick = 1'b0;
    model_start();
    checks++;
    if ({result, count, busy} !== {20'd0, 3'd0, 1'b1})
      $display("FAIL prio_start_over_tick: got %0d/%0d/%0d want 0/0/1", result, count, busy);
    else passed++;
    tick_once(MODE_ADD, 8'd2, 8'd0, 1'b0);
    void'(pop_exp());
    clear = 1'b1; tick = 1'b1;
    step();
    clear = 1'b0; tick = 1'b0; m_run = 0;
    tick_once(MODE_ADD, 8'd4, 8'd0, 1'b0);
    checks++;
    if ({result, count, busy} !== {20'd0, 3'd0, 1'b0})
      $display("FAIL clear_midrun_then_idle_tick: got %0d/%0d/%0d want 0/0/0", result, count, busy);
    else passed++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [1:0] modes [4];
    modes[0] = MODE_ADDXY; modes[1] = MODE_MAC; modes[2] = MODE_SUB; modes[3] = MODE_ADD;
    do_start();
    for (int i = 0; i < 4; i++) begin
      tick_once(modes[i], 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
      e = pop_exp();
      checks++;
      if ({result, count, ovf, done} !== {e.res, e.cnt, e.ovf, e.dn})
        $display("FAIL b2b_tick%0d: got %h want %h", i, {result, count, ovf, done},
                 {e.res, e.cnt, e.ovf, e.dn});
      else passed++;
    end
  endtask

  task automatic test_reset_midrun();
    exp_t e;
    int   done_seen;
    do_start();
    tick_once(MODE_ADD, 8'd3, 8'd0, 1'b0);
    tick_once(MODE_ADD, 8'd3, 8'd0, 1'b0);
    void'(pop_exp());
    e = pop_exp();
    checks++;
    if ({result, count} !== {20'd6, 3'd2} || result !== e.res)
      $display("FAIL reset_pre: got %0d/%0d want 6/2", result, count);
    else passed++;
    reset = 1'b1; start = 1'b1; tick = 1'b1;
    step();
    reset = 1'b0; start = 1'b0; tick = 1'b0; m_run = 0;
    checks++;
    if ({result, count, busy, done, ovf} !== 27'd0)
      $display("FAIL reset_midrun: got %h want 0", {result, count, busy, done, ovf});
    else passed++;
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick_once(MODE_ADD, 8'd3, 8'd0, 1'b0);
      if (done || busy || result != 20'd0) done_seen++;
    end
    checks++;
    if (done_seen != 0)
      $display("FAIL reset_stays_idle: got %0d bad cycles want 0", done_seen);
    else passed++;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; start = 1'b0; clear = 1'b0; hold = 1'b0;
    mode = 2'b00; X = '0; Y = '0;
    m_acc = 0; m_cnt = 0; m_ovf = 0; m_run = 0;
    test_reset();
    test_add();
    test_mac();
    test_sub();
    test_hold();
    test_priority();
    test_back_to_back();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
